// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM/WB data path: load types, access sizes, stage states.
package rv_mem_pkg;

    typedef enum logic [2:0] {
        LdNone = 3'd0,
        LdB    = 3'd1,
        LdH    = 3'd2,
        LdW    = 3'd3,
        LdBu   = 3'd4,
        LdHu   = 3'd5,
        LdWu   = 3'd6,
        LdD    = 3'd7
    } load_type_e;

    typedef enum logic [1:0] {
        SzByte  = 2'd0,
        SzHalf  = 2'd1,
        SzWord  = 2'd2,
        SzDword = 2'd3
    } mem_size_e;

    typedef logic state_t;
    localparam state_t StIdle = 1'b0;
    localparam state_t StWait = 1'b1;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SzByte:  size_mask = 8'h01;
            SzHalf:  size_mask = 8'h03;
            SzWord:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the byte/half/word/dword at a lane offset and sign- or zero-extends it to XLEN.
module load_extend
    import rv_mem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       load_type,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (load_type)
            LdB:  data = XLEN'($signed(shifted[7:0]));
            LdBu: data = XLEN'(shifted[7:0]);
            LdH:  data = XLEN'($signed(shifted[15:0]));
            LdHu: data = XLEN'(shifted[15:0]);
            // On a 32-bit datapath LWU and LD collapse to LW.
            LdWu: data = (XLEN == 64) ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            LdD:  data = (XLEN == 64) ? shifted : XLEN'($signed(shifted[31:0]));
            default: data = XLEN'($signed(shifted[31:0]));
        endcase
    end

endmodule

// File: rtl/wb_mem_stage.sv
// MEM/WB write-back stage talking to data memory over a variable-latency req/ack handshake.
module wb_mem_stage
    import rv_mem_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned LANES = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bubbleW,
    input  logic                flushW,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                wb_select,
    input  logic [2:0]          load_type,
    input  logic [1:0]          store_size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [LANES-1:0]    mem_be,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     data_WB,
    output logic                wb_valid,
    output logic                stall_req,
    output logic                misalign
);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [2:0]              lt_q, lt_d;
    logic                    wbsel_q, wbsel_d;
    logic                    is_load_q, is_load_d;
    logic                    we_q, we_d;
    logic                    dead_q, dead_d;
    logic                    mis_q, mis_d;
    logic                    wbv_q, wbv_d;
    logic [LANES-1:0]        be_q, be_d;
    logic [ADDR_W-OFF_W-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0]         mwdata_q, mwdata_d;
    logic [XLEN-1:0]         data_q, data_d;

    logic [1:0]       size_sel;
    logic             aligned;
    logic [OFF_W-1:0] offset;
    logic [15:0]      be_wide;
    logic [XLEN-1:0]  ext_data;
    logic             ack_hit;
    logic             load_wb;
    logic [XLEN-1:0]  ack_data;

    assign offset  = addr[OFF_W-1:0];
    assign be_wide = 16'(size_mask(size_sel)) << offset;

    always_comb begin
        size_sel = store_size;
        if (is_load) begin
            case (load_type)
                LdB, LdBu: size_sel = SzByte;
                LdH, LdHu: size_sel = SzHalf;
                LdD:       size_sel = SzDword;
                default:   size_sel = SzWord;
            endcase
        end
        case (size_sel)
            SzByte:  aligned = 1'b1;
            SzHalf:  aligned = ~addr[0];
            SzWord:  aligned = (addr[1:0] == 2'b00);
            default: aligned = (XLEN == 64) && (addr[2:0] == 3'b000);
        endcase
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .rdata     (mem_rdata),
        .offset    (addr_q[OFF_W-1:0]),
        .load_type (lt_q),
        .data      (ext_data)
    );

    // A flush arriving on the ack cycle itself also kills the write-back.
    assign ack_hit  = (state_q == StWait) && mem_ack;
    assign load_wb  = ack_hit && is_load_q && !dead_q && !flushW;
    assign ack_data = !load_wb ? '0 : (wbsel_q ? ext_data : XLEN'(addr_q));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lt_d     = lt_q;
        wbsel_d  = wbsel_q;
        is_load_d = is_load_q;
        we_d     = we_q;
        dead_d   = dead_q;
        be_d     = be_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        data_d   = data_q;
        mis_d    = 1'b0;
        wbv_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bubbleW) begin
                    // hold everything
                end else if (flushW) begin
                    addr_d    = '0;
                    lt_d      = '0;
                    wbsel_d   = 1'b0;
                    is_load_d = 1'b0;
                    we_d      = 1'b0;
                    dead_d    = 1'b0;
                    be_d      = '0;
                    maddr_d   = '0;
                    mwdata_d  = '0;
                    data_d    = '0;
                end else begin
                    addr_d    = addr;
                    lt_d      = load_type;
                    wbsel_d   = wb_select;
                    is_load_d = is_load;
                    we_d      = is_store & ~is_load;
                    dead_d    = 1'b0;
                    be_d      = '0;
                    data_d    = '0;
                    if ((is_load || is_store) && aligned) begin
                        state_d  = StWait;
                        be_d     = be_wide[LANES-1:0];
                        maddr_d  = addr[ADDR_W-1:OFF_W];
                        mwdata_d = wdata << {offset, 3'b000};
                    end else if (is_load || is_store) begin
                        mis_d = 1'b1;
                        we_d  = 1'b0;
                    end else begin
                        wbv_d  = 1'b1;
                        data_d = XLEN'(addr);
                    end
                end
            end
            default: begin
                if (flushW) dead_d = 1'b1;
                if (mem_ack) begin
                    state_d = StIdle;
                    data_d  = ack_data;
                    dead_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            lt_q      <= '0;
            wbsel_q   <= 1'b0;
            is_load_q <= 1'b0;
            we_q      <= 1'b0;
            dead_q    <= 1'b0;
            mis_q     <= 1'b0;
            wbv_q     <= 1'b0;
            be_q      <= '0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lt_q      <= lt_d;
            wbsel_q   <= wbsel_d;
            is_load_q <= is_load_d;
            we_q      <= we_d;
            dead_q    <= dead_d;
            mis_q     <= mis_d;
            wbv_q     <= wbv_d;
            be_q      <= be_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            data_q    <= data_d;
        end
    end

    assign mem_req   = (state_q == StWait);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be_q : '0;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign data_WB   = ack_hit ? ack_data : data_q;
    assign wb_valid  = wbv_q | load_wb;
    assign stall_req = mem_req & ~mem_ack;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_wb_mem_stage.sv
// Directed, table-driven bench for wb_mem_stage at XLEN=32, with a second XLEN=64 instance.
module tb_wb_mem_stage;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, bubbleW, flushW, is_load, is_store, wb_select, mem_ack;
    logic [2:0]  load_type;
    logic [1:0]  store_size;
    logic [31:0] addr, wdata, rdata;
    logic [63:0] rdata64;

    logic        req32, we32, wbv32, stall32, mis32;
    logic [3:0]  be32;
    logic [29:0] maddr32;
    logic [31:0] mwdata32, data32;

    logic        req64, we64, wbv64, stall64, mis64;
    logic [7:0]  be64;
    logic [28:0] maddr64;
    logic [63:0] mwdata64, data64;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_mem_stage #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bubbleW(bubbleW), .flushW(flushW),
        .is_load(is_load), .is_store(is_store), .wb_select(wb_select),
        .load_type(load_type), .store_size(store_size), .addr(addr), .wdata(wdata),
        .mem_req(req32), .mem_we(we32), .mem_be(be32), .mem_addr(maddr32),
        .mem_wdata(mwdata32), .mem_ack(mem_ack), .mem_rdata(rdata),
        .data_WB(data32), .wb_valid(wbv32), .stall_req(stall32), .misalign(mis32)
    );

    wb_mem_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .bubbleW(bubbleW), .flushW(flushW),
        .is_load(is_load), .is_store(is_store), .wb_select(wb_select),
        .load_type(load_type), .store_size(store_size), .addr(addr),
        .wdata({32'h0, wdata}),
        .mem_req(req64), .mem_we(we64), .mem_be(be64), .mem_addr(maddr64),
        .mem_wdata(mwdata64), .mem_ack(mem_ack), .mem_rdata(rdata64),
        .data_WB(data64), .wb_valid(wbv64), .stall_req(stall64), .misalign(mis64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld, st, wsel;
        logic [2:0]  lt;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, rdata;
        logic        req, we;
        logic [3:0]  be;
        logic [29:0] maddr;
        logic [31:0] mwdata, data;
        logic        valid, mis;
    } vec_t;

    vec_t vecs[13];

    task automatic drive(input logic ld, input logic st, input logic wsel, input logic [2:0] lt,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        is_load = ld; is_store = st; wb_select = wsel; load_type = lt;
        store_size = sz; addr = a; wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0; bubbleW = 1'b1; flushW = 1'b0; mem_ack = 1'b0;
        rdata = '0; rdata64 = '0;
        drive(1'b0, 1'b0, 1'b0, LdNone, SzByte, 32'h0, 32'h0);

        //                 ld st ws lt    sz       addr         wdata        rdata         req we be       maddr      mwdata        data          v  m
        vecs[0]  = '{1, 0, 1, LdW,  SzByte,  32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 30'h40, 32'h0,        32'hDEADBEEF, 1, 0};
        vecs[1]  = '{0, 1, 0, LdNone, SzHalf, 32'h22, 32'h1234,     32'h0,        1, 1, 4'b1100, 30'h08, 32'h12340000, 32'h0,        0, 0};
        vecs[2]  = '{1, 0, 1, LdW,  SzByte,  32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,  32'h0,        32'h0,        0, 1};
        vecs[3]  = '{1, 0, 1, LdBu, SzByte,  32'h102, 32'h0,        32'h00AB0000, 1, 0, 4'b0100, 30'h40, 32'h0,        32'h000000AB, 1, 0};
        vecs[4]  = '{1, 0, 1, LdH,  SzByte,  32'h102, 32'h0,        32'h80010000, 1, 0, 4'b1100, 30'h40, 32'h0,        32'hFFFF8001, 1, 0};
        vecs[5]  = '{1, 0, 1, LdHu, SzByte,  32'h106, 32'h0,        32'h80010000, 1, 0, 4'b1100, 30'h41, 32'h0,        32'h00008001, 1, 0};
        vecs[6]  = '{0, 1, 0, LdNone, SzByte, 32'h07, 32'h000000A5, 32'h0,        1, 1, 4'b1000, 30'h01, 32'hA5000000, 32'h0,        0, 0};
        vecs[7]  = '{0, 1, 0, LdNone, SzWord, 32'h10, 32'hCAFEF00D, 32'h0,        1, 1, 4'b1111, 30'h04, 32'hCAFEF00D, 32'h0,        0, 0};
        vecs[8]  = '{1, 0, 1, LdH,  SzByte,  32'h103, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,  32'h0,        32'h0,        0, 1};
        vecs[9]  = '{0, 0, 0, LdNone, SzByte, 32'h55, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,  32'h0,        32'h55,       1, 0};
        vecs[10] = '{1, 0, 1, LdD,  SzByte,  32'h08,  32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,  32'h0,        32'h0,        0, 1};
        vecs[11] = '{0, 1, 0, LdNone, SzDword, 32'h0, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,  32'h0,        32'h0,        0, 1};
        vecs[12] = '{1, 0, 1, LdWu, SzByte,  32'h04,  32'h0,        32'h80000000, 1, 0, 4'b1111, 30'h01, 32'h0,        32'h80000000, 1, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req32, 0);
        chk("rst_we", we32, 0);
        chk("rst_be", be32, 0);
        chk("rst_stall", stall32, 0);
        chk("rst_valid", wbv32, 0);
        chk("rst_mis", mis32, 0);
        chk("rst_data", data32, 0);
        rst_n = 1'b1;

        // Each vector: capture, then one cycle with ack already high (latency 1).
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].ld, vecs[i].st, vecs[i].wsel, vecs[i].lt, vecs[i].sz,
                  vecs[i].addr, vecs[i].wdata);
            rdata = vecs[i].rdata; mem_ack = 1'b1; bubbleW = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), req32, vecs[i].req);
            chk($sformatf("v%0d_data", i), data32, vecs[i].data);
            chk($sformatf("v%0d_valid", i), wbv32, vecs[i].valid);
            chk($sformatf("v%0d_mis", i), mis32, vecs[i].mis);
            chk($sformatf("v%0d_stall", i), stall32, 0);
            if (vecs[i].req) begin
                chk($sformatf("v%0d_we", i), we32, vecs[i].we);
                chk($sformatf("v%0d_be", i), be32, vecs[i].be);
                chk($sformatf("v%0d_maddr", i), maddr32, vecs[i].maddr);
                if (vecs[i].we) chk($sformatf("v%0d_mwdata", i), mwdata32, vecs[i].mwdata);
            end
            bubbleW = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end

        // Latency-4 byte load: three stalled cycles with request fields held.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, LdB, SzByte, 32'h103, 32'h0);
        rdata = 32'h80000000; bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lat4_stall%0d", c), stall32, 1);
            chk($sformatf("lat4_req%0d", c), req32, 1);
            chk($sformatf("lat4_maddr%0d", c), maddr32, 30'h40);
            chk($sformatf("lat4_be%0d", c), be32, 4'b1000);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        #1;
        chk("lat4_ack_stall", stall32, 0);
        chk("lat4_ack_data", data32, 32'hFFFFFF80);
        chk("lat4_ack_valid", wbv32, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lat4_idle_req", req32, 0);
        chk("lat4_hold_data", data32, 32'hFFFFFF80);
        chk("lat4_hold_valid", wbv32, 0);

        // Flush while a 3-cycle load is outstanding.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, LdW, SzByte, 32'h200, 32'h0);
        rdata = 32'h11111111; bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1; flushW = 1'b1;
        @(negedge clk);
        flushW = 1'b0;
        chk("flw_stall", stall32, 1);
        chk("flw_req", req32, 1);
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        chk("flw_ack_valid", wbv32, 0);
        chk("flw_ack_data", data32, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("flw_idle_req", req32, 0);
        chk("flw_idle_data", data32, 0);
        chk("flw_idle_stall", stall32, 0);

        // Reset in the middle of WAIT abandons the request.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, LdNone, SzWord, 32'h300, 32'h89ABCDEF);
        bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1;
        chk("rsw_req_before", req32, 1);
        chk("rsw_we_before", we32, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rsw_req", req32, 0);
        chk("rsw_we", we32, 0);
        chk("rsw_be", be32, 0);
        chk("rsw_stall", stall32, 0);
        chk("rsw_valid", wbv32, 0);
        chk("rsw_data", data32, 0);

        // ALU result followed by two bubbles: result holds, nothing new captured.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, LdNone, SzByte, 32'h55, 32'h0);
        bubbleW = 1'b0;
        @(negedge clk);
        chk("hold_data0", data32, 32'h55);
        chk("hold_valid0", wbv32, 1);
        bubbleW = 1'b1;
        drive(1'b1, 1'b0, 1'b1, LdW, SzByte, 32'h77, 32'h0);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold_data%0d", c), data32, 32'h55);
            chk($sformatf("hold_valid%0d", c), wbv32, 0);
            chk($sformatf("hold_req%0d", c), req32, 0);
        end
        // Flush in IDLE clears the held result.
        bubbleW = 1'b0; flushW = 1'b1;
        @(negedge clk);
        chk("flidle_data", data32, 0);
        chk("flidle_valid", wbv32, 0);
        chk("flidle_req", req32, 0);
        flushW = 1'b0; bubbleW = 1'b1;

        // 64-bit datapath: LD, LW and LWU.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, LdD, SzByte, 32'h8, 32'h0);
        rdata64 = 64'h8877665544332211; mem_ack = 1'b1; bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1;
        chk("x64_ld_req", req64, 1);
        chk("x64_ld_be", be64, 8'hFF);
        chk("x64_ld_maddr", maddr64, 29'h1);
        chk("x64_ld_data", data64, 64'h8877665544332211);
        chk("x64_ld_valid", wbv64, 1);
        chk("x32_ld_mis", mis32, 1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, LdW, SzByte, 32'hC, 32'h0);
        rdata64 = 64'h80000000_00000000; bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1;
        chk("x64_lw_be", be64, 8'hF0);
        chk("x64_lw_data", data64, 64'hFFFFFFFF_80000000);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, LdWu, SzByte, 32'hC, 32'h0);
        bubbleW = 1'b0;
        @(negedge clk);
        bubbleW = 1'b1;
        chk("x64_lwu_data", data64, 64'h00000000_80000000);
        chk("x64_lwu_valid", wbv64, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_stage.md
Name: wb_mem_stage

Overview:
- Parametrised MEM/WB write-back data stage for the RV core.
- The current block assumes a fixed 1-cycle synchronous data cache. This block talks to any data memory through a req/ack handshake with variable latency.
- It generates lane byte-enables, aligns store data, sign/zero-extends loads for XLEN 32 or 64, and detects misaligned accesses.
- It raises a stall request to the hazard unit while an access is outstanding. Sits between the EX/MEM register outputs and the register-file write port.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- ADDR_W, 32, byte-address width.
- LANES, XLEN/8, derived; number of byte lanes.
- OFF_W, log2(LANES), derived; width of the in-word byte offset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- bubbleW  in  1  hold the WB stage.
- flushW  in  1  clear the WB stage.
- is_load  in  1  MEM-stage instruction is a load.
- is_store  in  1  MEM-stage instruction is a store.
- wb_select  in  1  0 = write back ALU result, 1 = write back load data.
- load_type  in  3  LB/LH/LW/LD/LBU/LHU/LWU (package encoding).
- store_size  in  2  byte/half/word/dword.
- addr  in  ADDR_W  ALU result; also the memory byte address.
- wdata  in  XLEN  store data, least-significant-byte aligned.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_be  out  LANES  lane byte-enables.
- mem_addr  out  ADDR_W-OFF_W  word address.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_ack  in  1  memory completion; valid only while mem_req=1.
- mem_rdata  in  XLEN  read word; valid when mem_ack=1.
- data_WB  out  XLEN  write-back data.
- wb_valid  out  1  data_WB is to be written this cycle.
- stall_req  out  1  stall IF..MEM and freeze the EX/MEM register.
- misalign  out  1  misaligned-access exception pulse.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - mem_req, mem_we, mem_be, stall_req, wb_valid, misalign all 0.
  - All captured registers 0, so data_WB=0.
  - Reset during WAIT abandons the request immediately; the memory shares rst_n.
- States: IDLE, WAIT.
- Alignment rule: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0. dword is illegal when XLEN=32 and is flagged as misaligned.
- Capture (posedge, state=IDLE, bubbleW=0):
  - Latch addr, wdata, load_type, wb_select, and the access kind.
  - Aligned load or store: next state is WAIT and mem_req rises on this edge.
  - mem_be = size mask << addr[OFF_W-1:0].
  - mem_wdata = wdata << 8*offset.
  - mem_addr = addr[ADDR_W-1:OFF_W].
  - Misaligned access: no request is issued; misalign=1 for exactly the following cycle, with wb_valid=0 and data_WB=0.
  - Non-memory instruction: data_WB = registered addr, wb_valid=1 the next cycle.
- WAIT:
  - mem_req and all request fields stay stable until mem_ack=1.
  - stall_req = 1 while in WAIT and mem_ack=0.
  - On the cycle mem_ack=1:
    - Loads: data_WB = load_extend(mem_rdata, captured offset, load_type), combinational, and wb_valid=1.
    - Stores: wb_valid=0.
    - At the next edge: mem_req drops, state returns to IDLE, data_WB is registered for hold.
  - mem_ack in the first WAIT cycle gives 1-cycle latency, identical to the previous cache timing.
- bubbleW=1 in IDLE: no capture; data_WB holds its previous value; wb_valid=0.
- bubbleW in WAIT: ignored.
- flushW=1 in IDLE: captured registers are cleared; data_WB=0; wb_valid=0. flushW has priority below bubbleW, as before.
- flushW during WAIT: the request is not cancelled. The entry is marked dead; stall_req keeps the same rule; at ack, data is discarded, wb_valid=0, and data_WB=0.
- mem_ack while mem_req=0: ignored.
- load_extend: selects the byte/half/word at the offset, then sign- or zero-extends to XLEN. The LWU/LD codes are treated as LW when XLEN=32.

Decomposition:
- Package rv_mem_pkg holds:
  - load_type codes (LB=1, LH=2, LW=3, LBU=4, LHU=5, LWU=6, LD=7, NONE=0);
  - store_size codes;
  - the state enum {IDLE, WAIT};
  - the size-to-mask function.
- One sub-module: load_extend, a parametrised-XLEN generalisation of the existing data extender.

Test Plan:
- Load with ack at latency 1 → XLEN=32: LW addr 0x100 with mem_rdata=0xDEADBEEF, ack in the first WAIT cycle → data_WB=0xDEADBEEF, wb_valid=1, stall_req stays 0.
- Load with ack at latency 4 → LB addr 0x103 with mem_rdata=0x80000000 → stall_req=1 for 3 cycles; mem_addr=0x40 and mem_be=4'b1000 held stable; data_WB=0xFFFFFF80 on the ack cycle.
- Aligned store → SH addr 0x22, wdata=0x1234 → mem_we=1, mem_be=4'b1100, mem_wdata=0x12340000, wb_valid=0.
- Misaligned access → LW addr 0x101 → mem_req stays 0, misalign=1 for one cycle, data_WB=0. Also at XLEN=64: LD addr 0x8 is accepted, mem_be=8'hFF.
- Flush and reset in WAIT:
  - flushW during a 3-cycle load → at ack wb_valid=0, data_WB=0, state IDLE.
  - rst_n=0 mid-WAIT → the next cycle shows mem_req=0 and all outputs 0.
- Hold behaviour → ALU result 0x55 (wb_select=0), then bubbleW=1 for 2 cycles → data_WB holds 0x55, wb_valid=0, no new capture.
